btn_event_ctrl: RTL and testbench
=================================

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 Parameter LONG_TICKS, default 1000: hold duration in ticks before the long-press event, legal range 2..2047.
REQ-002 Parameter REP_TICKS, default 200: auto-repeat period in ticks while held after the long-press event, legal range 2..2047.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-clk strobe, nominally 1 ms; the same strobe that drives the button debouncer.
REQ-006 btnDb  input  2  debounced button levels, 1 = pressed; bit i is button i.
REQ-007 shortEvt  output  2  one-clk pulse per button on release before the long threshold.
REQ-008 longEvt  output  2  one-clk pulse per button when the long threshold is reached.
REQ-009 repEvt  output  2  one-clk pulse per button at each repeat period after longEvt.
REQ-010 comboEvt  output  1  one-clk pulse when both buttons become pressed together.
REQ-011 busy  output  2  bit i = 1 while FSM i is not in IDLE.

Function
REQ-012 Each button has its own FSM with states IDLE, PRESS, HOLD and LOCK, plus an 11-bit tick counter cnt[i].
REQ-013 All outputs are registered; each event pulse is high for exactly one clk, in the cycle after the edge where its condition is sampled.
REQ-014 IDLE: btnDb[i]=1 -> PRESS, cnt[i]<=0.
REQ-015 PRESS: btnDb[i]=0 -> IDLE with shortEvt[i] pulse; otherwise on tick, if cnt[i]==LONG_TICKS-1 -> HOLD, cnt[i]<=0, longEvt[i] pulse, else cnt[i]++.
REQ-016 HOLD: btnDb[i]=0 -> IDLE with no pulse; otherwise on tick, if cnt[i]==REP_TICKS-1 -> repEvt[i] pulse, cnt[i]<=0, else cnt[i]++.
REQ-017 LOCK: no events are emitted and cnt[i] is held; btnDb[i]=0 -> IDLE.
REQ-018 Combo condition: btnDb==2'b11 this cycle, btnDb!=2'b11 in the previous cycle, and both FSMs in IDLE or PRESS.
- When met: comboEvt pulse, both FSMs -> LOCK, cnt cleared.
- The condition has priority over every per-button transition in the same cycle, including any longEvt due on that tick.
REQ-019 btnDb==2'b11 arising while either FSM is in HOLD yields no combo; the other button proceeds independently through IDLE/PRESS/HOLD.
REQ-020 Release wins over tick: if btnDb[i]=0 and tick=1 in the same cycle in PRESS or HOLD, only the release transition applies (short pulse from PRESS, none from HOLD).
REQ-021 Without tick, counters do not advance; level changes on btnDb are acted on every clk regardless of tick.
REQ-022 Counters never wrap: cnt[i] is cleared on every state entry, and comparisons use the parameter minus one.
REQ-023 At most one of shortEvt[i], longEvt[i], repEvt[i] is high per button per cycle; comboEvt never coincides with any per-button pulse.

Reset
REQ-024 rst_n=0 asynchronously forces both FSMs to IDLE, cnt to 0 and all outputs (shortEvt, longEvt, repEvt, comboEvt, busy) to 0; the previous-btnDb register also resets to 2'b00.
REQ-025 After reset release with a button already held: that FSM enters PRESS on the first clk and times from 0.
- If both buttons are held at release, comboEvt fires on the first clk, since the previous-btnDb register is 00.
REQ-026 Reset asserted mid-hold or mid-repeat aborts with no trailing pulse.

Verification (LONG_TICKS=5, REP_TICKS=3, tick every 4 clk)
REQ-027 btnDb[0] high for 3 ticks, then low -> exactly one shortEvt[0] pulse, one clk after release; no longEvt.
REQ-028 btnDb[1] held 12 ticks -> longEvt[1] on the 5th tick, repEvt[1] on the 8th and 11th ticks; release -> no shortEvt.
REQ-029 btnDb 00->01, then 11 two ticks later, then 00 -> one comboEvt; busy=11 until release; no short/long/rep on either button.
REQ-030 btnDb[0] held into HOLD, then btnDb[1] pressed -> no comboEvt; shortEvt[1] on release of button 1; repEvt[0] continues.
REQ-031 Release coincident with the 5th tick in PRESS -> shortEvt pulse only, no longEvt.
REQ-032 rst_n pulsed low during HOLD with tick active -> all outputs 0 immediately and no pulses until a fresh press.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// Two-button event controller: short press, long press, auto-repeat and a
// two-button combo, all timed in ticks of the shared debouncer strobe.
module btn_event_ctrl #(
    parameter int LONG_TICKS = 1000,
    parameter int REP_TICKS  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [1:0] btnDb,
    output logic [1:0] shortEvt,
    output logic [1:0] longEvt,
    output logic [1:0] repEvt,
    output logic       comboEvt,
    output logic [1:0] busy
);

    typedef enum logic [1:0] {IDLE, PRESS, HOLD, LOCK} state_t;

    localparam logic [10:0] LONG_LAST = 11'(LONG_TICKS - 1);
    localparam logic [10:0] REP_LAST  = 11'(REP_TICKS - 1);

    state_t      state     [2];
    state_t      state_nxt [2];
    logic [10:0] cnt       [2];
    logic [10:0] cnt_nxt   [2];
    logic [1:0]  btn_p1;
    logic [1:0]  short_nxt;
    logic [1:0]  long_nxt;
    logic [1:0]  rep_nxt;
    logic [1:0]  busy_nxt;
    logic        combo;

    always_comb begin
        // A fresh 11 only counts as a combo while neither button has gone long.
        combo = (btnDb == 2'b11) && (btn_p1 != 2'b11) &&
                (state[0] == IDLE || state[0] == PRESS) &&
                (state[1] == IDLE || state[1] == PRESS);
        short_nxt = '0;
        long_nxt  = '0;
        rep_nxt   = '0;
        busy_nxt  = '0;
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            if (combo) begin
                state_nxt[i] = LOCK;
                cnt_nxt[i]   = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (btnDb[i]) begin
                            state_nxt[i] = PRESS;
                            cnt_nxt[i]   = '0;
                        end
                    end
                    PRESS: begin
                        if (!btnDb[i]) begin
                            state_nxt[i] = IDLE;
                            cnt_nxt[i]   = '0;
                            short_nxt[i] = 1'b1;
                        end else if (tick) begin
                            if (cnt[i] == LONG_LAST) begin
                                state_nxt[i] = HOLD;
                                cnt_nxt[i]   = '0;
                                long_nxt[i]  = 1'b1;
                            end else begin
                                cnt_nxt[i] = cnt[i] + 11'd1;
                            end
                        end
                    end
                    HOLD: begin
                        if (!btnDb[i]) begin
                            state_nxt[i] = IDLE;
                            cnt_nxt[i]   = '0;
                        end else if (tick) begin
                            if (cnt[i] == REP_LAST) begin
                                cnt_nxt[i] = '0;
                                rep_nxt[i] = 1'b1;
                            end else begin
                                cnt_nxt[i] = cnt[i] + 11'd1;
                            end
                        end
                    end
                    LOCK: begin
                        if (!btnDb[i]) begin
                            state_nxt[i] = IDLE;
                            cnt_nxt[i]   = '0;
                        end
                    end
                    default: begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                    end
                endcase
            end
            busy_nxt[i] = (state_nxt[i] != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state[0] <= IDLE;
            state[1] <= IDLE;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
            btn_p1   <= '0;
            shortEvt <= '0;
            longEvt  <= '0;
            repEvt   <= '0;
            comboEvt <= 1'b0;
            busy     <= '0;
        end else begin
            state[0] <= state_nxt[0];
            state[1] <= state_nxt[1];
            cnt[0]   <= cnt_nxt[0];
            cnt[1]   <= cnt_nxt[1];
            btn_p1   <= btnDb;
            shortEvt <= short_nxt;
            longEvt  <= long_nxt;
            repEvt   <= rep_nxt;
            comboEvt <= combo;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: segment table, timing corner sequences and a
// randomized run against a tick-counting reference model.
module tb_btn_event_ctrl;

    localparam int L = 5;
    localparam int R = 3;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [1:0] btnDb;
    logic [1:0] shortEvt;
    logic [1:0] longEvt;
    logic [1:0] repEvt;
    logic       comboEvt;
    logic [1:0] busy;

    btn_event_ctrl #(.LONG_TICKS(L), .REP_TICKS(R)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .btnDb    (btnDb),
        .shortEvt (shortEvt),
        .longEvt  (longEvt),
        .repEvt   (repEvt),
        .comboEvt (comboEvt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] b;
        int         nper;
        int         sh0, sh1, lg0, lg1, rp0, rp1, cb;
        logic [1:0] busy;
    } vec_t;

    vec_t tbl[$];

    int checks = 0;
    int passed = 0;
    int c_sh0, c_sh1, c_lg0, c_lg1, c_rp0, c_rp1, c_cb;

    // Reference model: counts ticks seen while a button is held.
    int         m_n    [2];
    bit         m_act  [2];
    bit         m_lock [2];
    logic [1:0] m_prev;
    logic [1:0] m_sh, m_lg, m_rp, m_busy;
    logic       m_cb;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            passed++;
    endtask

    task automatic clk_step(input logic [1:0] b, input logic t);
        @(negedge clk);
        btnDb = b;
        tick  = t;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seg(input logic [1:0] b, input int nper);
        c_sh0 = 0; c_sh1 = 0; c_lg0 = 0; c_lg1 = 0; c_rp0 = 0; c_rp1 = 0; c_cb = 0;
        for (int p = 0; p < nper; p++) begin
            for (int k = 0; k < 4; k++) begin
                clk_step(b, k == 3);
                c_sh0 += int'(shortEvt[0]);
                c_sh1 += int'(shortEvt[1]);
                c_lg0 += int'(longEvt[0]);
                c_lg1 += int'(longEvt[1]);
                c_rp0 += int'(repEvt[0]);
                c_rp1 += int'(repEvt[1]);
                c_cb  += int'(comboEvt);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_act[i] = 0; m_lock[i] = 0;
        end
        m_prev = 2'b00;
        m_sh = '0; m_lg = '0; m_rp = '0; m_busy = '0; m_cb = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] b, input logic t);
        bit cmb;
        m_sh = '0; m_lg = '0; m_rp = '0; m_cb = 1'b0;
        cmb = (b == 2'b11) && (m_prev != 2'b11);
        for (int i = 0; i < 2; i++)
            if (m_lock[i] || (m_act[i] && m_n[i] >= L)) cmb = 0;
        if (cmb) begin
            m_cb = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1; m_lock[i] = 1; m_n[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i]) begin
                    if (b[i]) begin m_act[i] = 1; m_n[i] = 0; end
                end else if (m_lock[i]) begin
                    if (!b[i]) begin m_act[i] = 0; m_lock[i] = 0; end
                end else if (!b[i]) begin
                    if (m_n[i] < L) m_sh[i] = 1'b1;
                    m_act[i] = 0;
                end else if (t) begin
                    m_n[i]++;
                    if (m_n[i] == L) m_lg[i] = 1'b1;
                    else if (m_n[i] > L && (m_n[i] - L) % R == 0) m_rp[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) m_busy[i] = m_act[i];
        m_prev = b;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, int'({shortEvt, longEvt, repEvt, comboEvt, busy}), 0);
    endtask

    initial begin
        logic [1:0] rb;
        logic       rt;
        string      nm;

        rst_n = 1'b0;
        btnDb = 2'b00;
        tick  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back('{2'b01,  3, 0, 0, 0, 0, 0, 0, 0, 2'b01});
        tbl.push_back('{2'b00,  2, 1, 0, 0, 0, 0, 0, 0, 2'b00});
        tbl.push_back('{2'b10, 12, 0, 0, 0, 1, 0, 2, 0, 2'b10});
        tbl.push_back('{2'b00,  2, 0, 0, 0, 0, 0, 0, 0, 2'b00});
        tbl.push_back('{2'b01,  2, 0, 0, 0, 0, 0, 0, 0, 2'b01});
        tbl.push_back('{2'b11,  3, 0, 0, 0, 0, 0, 0, 1, 2'b11});
        tbl.push_back('{2'b00,  2, 0, 0, 0, 0, 0, 0, 0, 2'b00});
        tbl.push_back('{2'b01,  6, 0, 0, 1, 0, 0, 0, 0, 2'b01});
        tbl.push_back('{2'b11,  2, 0, 0, 0, 0, 1, 0, 0, 2'b11});
        tbl.push_back('{2'b01,  3, 0, 1, 0, 0, 1, 0, 0, 2'b01});
        tbl.push_back('{2'b00,  2, 0, 0, 0, 0, 0, 0, 0, 2'b00});
        tbl.push_back('{2'b11,  1, 0, 0, 0, 0, 0, 0, 1, 2'b11});
        tbl.push_back('{2'b00,  1, 0, 0, 0, 0, 0, 0, 0, 2'b00});
        tbl.push_back('{2'b10,  2, 0, 0, 0, 0, 0, 0, 0, 2'b10});
        tbl.push_back('{2'b11,  1, 0, 0, 0, 0, 0, 0, 1, 2'b11});
        tbl.push_back('{2'b10,  6, 0, 0, 0, 0, 0, 0, 0, 2'b10});
        tbl.push_back('{2'b00,  1, 0, 0, 0, 0, 0, 0, 0, 2'b00});

        foreach (tbl[r]) begin
            run_seg(tbl[r].b, tbl[r].nper);
            nm = $sformatf("row%0d", r);
            chk({nm, "_short0"}, c_sh0, tbl[r].sh0);
            chk({nm, "_short1"}, c_sh1, tbl[r].sh1);
            chk({nm, "_long0"},  c_lg0, tbl[r].lg0);
            chk({nm, "_long1"},  c_lg1, tbl[r].lg1);
            chk({nm, "_rep0"},   c_rp0, tbl[r].rp0);
            chk({nm, "_rep1"},   c_rp1, tbl[r].rp1);
            chk({nm, "_combo"},  c_cb,  tbl[r].cb);
            chk({nm, "_busy"},   int'(busy), int'(tbl[r].busy));
        end

        // Short press: pulse exactly one clk after the release edge.
        run_seg(2'b01, 3);
        clk_step(2'b00, 1'b0);
        chk("short_timing", int'(shortEvt), 1);
        chk("short_timing_long", int'(longEvt), 0);
        clk_step(2'b00, 1'b0);
        chk("short_one_clk", int'(shortEvt), 0);

        // Release coincident with the tick that would reach the long threshold.
        run_seg(2'b01, 4);
        repeat (3) clk_step(2'b01, 1'b0);
        clk_step(2'b00, 1'b1);
        chk("rel_vs_tick_short", int'(shortEvt), 1);
        chk("rel_vs_tick_long", int'(longEvt), 0);
        clk_step(2'b00, 1'b0);
        chk("rel_vs_tick_after", int'({shortEvt, longEvt}), 0);

        // Asynchronous reset in the middle of a hold, with tick active.
        run_seg(2'b10, 6);
        chk("hold_busy", int'(busy), 2);
        @(negedge clk);
        tick = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_now");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        btnDb = 2'b00;
        tick  = 1'b0;
        rst_n = 1'b1;
        run_seg(2'b00, 3);
        chk("post_reset_pulses", c_sh0 + c_sh1 + c_lg0 + c_lg1 + c_rp0 + c_rp1 + c_cb, 0);
        chk("post_reset_busy", int'(busy), 0);

        // Both buttons held across reset release: combo on the first clk.
        @(negedge clk);
        rst_n = 1'b0;
        btnDb = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_rel_combo", int'(comboEvt), 1);
        chk("reset_rel_busy", int'(busy), 3);
        run_seg(2'b00, 1);

        // Randomized run against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        btnDb = 2'b00;
        tick  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rb = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) rb[0] = ~rb[0];
            if ($urandom_range(0, 11) == 0) rb[1] = ~rb[1];
            if ($urandom_range(0, 59) == 0) rb = 2'b11;
            rt = ($urandom_range(0, 3) == 0);
            clk_step(rb, rt);
            model_step(rb, rt);
            chk($sformatf("rand%0d", c),
                int'({shortEvt, longEvt, repEvt, comboEvt, busy}),
                int'({m_sh, m_lg, m_rp, m_cb, m_busy}));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
